// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Five-state multicycle RV32I-subset controller with halt-on-illegal option.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        load_pc,
    output logic        pc_src,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_SRL = 4'b1000;
    localparam logic [3:0] c_ALU_SLL = 4'b1001;
    localparam logic [3:0] c_ALU_SRA = 4'b1010;
    localparam logic [3:0] c_ALU_XOR = 4'b1101;

    localparam logic [6:0] c_OPC_R    = 7'b0110011;
    localparam logic [6:0] c_OPC_I    = 7'b0010011;
    localparam logic [6:0] c_OPC_LW   = 7'b0000011;
    localparam logic [6:0] c_OPC_SW   = 7'b0100011;
    localparam logic [6:0] c_OPC_BEQ  = 7'b1100011;

    state_t      r_state;
    logic [31:0] r_ir;
    logic        r_zero_q;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_write;
    logic        r_load_pc;
    logic        r_pc_src;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic        w_f7_base;
    logic        w_f7_alt;
    logic        w_legal;
    logic [3:0]  w_op;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_beq;
    logic        w_unused_ir;

    assign w_opcode    = r_ir[6:0];
    assign w_f3        = r_ir[14:12];
    assign w_f7_base   = (r_ir[31:25] == 7'b0000000);
    assign w_f7_alt    = (r_ir[31:25] == 7'b0100000);
    assign w_unused_ir = ^{r_ir[24:15], r_ir[11:7]};

    always_comb begin
        w_legal = 1'b0;
        w_op    = c_ALU_ADD;
        unique case (w_opcode)
            c_OPC_R: begin
                case (w_f3)
                    3'b000: begin w_legal = w_f7_base | w_f7_alt; w_op = w_f7_alt ? c_ALU_SUB : c_ALU_ADD; end
                    3'b001: begin w_legal = w_f7_base; w_op = c_ALU_SLL; end
                    3'b010: begin w_legal = w_f7_base; w_op = c_ALU_SLT; end
                    3'b100: begin w_legal = w_f7_base; w_op = c_ALU_XOR; end
                    3'b101: begin w_legal = w_f7_base | w_f7_alt; w_op = w_f7_alt ? c_ALU_SRA : c_ALU_SRL; end
                    3'b110: begin w_legal = w_f7_base; w_op = c_ALU_OR;  end
                    3'b111: begin w_legal = w_f7_base; w_op = c_ALU_AND; end
                    default: w_legal = 1'b0;
                endcase
            end
            c_OPC_I: begin
                // Only shifts constrain ir[31:25]; other I-ALU ops carry immediate bits there
                case (w_f3)
                    3'b000: begin w_legal = 1'b1; w_op = c_ALU_ADD; end
                    3'b001: begin w_legal = w_f7_base; w_op = c_ALU_SLL; end
                    3'b010: begin w_legal = 1'b1; w_op = c_ALU_SLT; end
                    3'b100: begin w_legal = 1'b1; w_op = c_ALU_XOR; end
                    3'b101: begin w_legal = w_f7_base | w_f7_alt; w_op = w_f7_alt ? c_ALU_SRA : c_ALU_SRL; end
                    3'b110: begin w_legal = 1'b1; w_op = c_ALU_OR;  end
                    3'b111: begin w_legal = 1'b1; w_op = c_ALU_AND; end
                    default: w_legal = 1'b0;
                endcase
            end
            c_OPC_LW:  begin w_legal = (w_f3 == 3'b010); w_op = c_ALU_ADD; end
            c_OPC_SW:  begin w_legal = (w_f3 == 3'b010); w_op = c_ALU_ADD; end
            c_OPC_BEQ: begin w_legal = (w_f3 == 3'b000); w_op = c_ALU_SUB; end
            default:   w_legal = 1'b0;
        endcase
    end

    assign w_is_r   = w_legal && (w_opcode == c_OPC_R);
    assign w_is_i   = w_legal && (w_opcode == c_OPC_I);
    assign w_is_lw  = w_legal && (w_opcode == c_OPC_LW);
    assign w_is_sw  = w_legal && (w_opcode == c_OPC_SW);
    assign w_is_beq = w_legal && (w_opcode == c_OPC_BEQ);

    // Strobes are registered on entry to the state that owns them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IF;
            r_ir        <= 32'd0;
            r_zero_q    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
            r_load_pc   <= 1'b0;
            r_pc_src    <= 1'b0;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
            r_load_pc   <= 1'b0;
            r_pc_src    <= 1'b0;
            case (r_state)
                S_IF: begin
                    r_ir    <= instr;
                    r_state <= S_ID;
                end
                S_ID: begin
                    if (!w_legal && HALT_ON_ILLEGAL)
                        r_state <= S_HALT;
                    else
                        r_state <= S_EX;
                end
                S_EX: begin
                    r_zero_q    <= zero;
                    r_mem_read  <= w_is_lw;
                    r_mem_write <= w_is_sw;
                    r_state     <= S_MEM;
                end
                S_MEM: begin
                    r_reg_write <= w_is_r | w_is_i | w_is_lw;
                    r_load_pc   <= 1'b1;
                    r_pc_src    <= w_is_beq & r_zero_q;
                    r_state     <= S_WB;
                end
                S_WB:    r_state <= S_IF;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IF;
            endcase
        end
    end

    assign state      = r_state;
    assign alu_op     = w_legal ? w_op : c_ALU_ADD;
    assign alu_src    = w_is_i | w_is_lw | w_is_sw;
    assign mem_to_reg = w_is_lw;
    assign illegal    = (r_state != S_IF) && !w_legal;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign reg_write  = r_reg_write;
    assign load_pc    = r_load_pc;
    assign pc_src     = r_pc_src;

endmodule
`default_nettype wire
